// File: rtl/dp_pkg.sv
// Shared datapath definitions for the generated mux/register components.
//   DP_DATAWIDTH : default data width shared with the 2:1 mux and its stages
//   skid_state_t : occupancy state of the mux output skid register
package dp_pkg;

    localparam int DP_DATAWIDTH = 8;

    // The encoding equals the occupancy, so the state value doubles as count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mux_skid_reg.sv
// Registered output stage placed after a 2:1 datapath mux. The mux result is
// captured under a valid/ready handshake into a 2-entry skid buffer, so
// in_ready comes straight from a flop and no combinational ready path runs
// back through the mux select logic.
//
// Ports:
//   Clk       in   rising-edge clock
//   Rst       in   synchronous reset, active-high
//   d         in   data from the mux output
//   in_valid  in   producer has meaningful data on d
//   in_ready  out  stage accepts d this cycle (registered)
//   q         out  registered output data
//   out_valid out  q is meaningful
//   out_ready in   consumer accepts q this cycle
//   count     out  number of words held (0..2)
//
// state | meaning
// EMPTY | nothing held
// BUSY  | one word, presented on q
// FULL  | two words: oldest on q, next in skid
module mux_skid_reg
    import dp_pkg::*;
#(
    parameter int DATAWIDTH = DP_DATAWIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] d,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           count
);

    skid_state_t          state;
    skid_state_t          next_state;
    logic [DATAWIDTH-1:0] q_reg;
    logic [DATAWIDTH-1:0] skid_reg;
    logic                 ready_reg;
    logic                 in_fire;
    logic                 out_fire;
    logic                 load_q;
    logic                 load_skid;
    logic                 q_from_skid;

    assign in_ready  = ready_reg;
    assign out_valid = (state != EMPTY);
    assign q         = q_reg;
    assign count     = 2'(state);
    assign in_fire   = in_valid & ready_reg;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        next_state  = state;
        load_q      = 1'b0;
        load_skid   = 1'b0;
        q_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_q     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_q = 1'b1;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    next_state = FULL;
                end else if (out_fire) begin
                    // q keeps its stale value; out_valid=0 makes it don't-care.
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    q_from_skid = 1'b1;
                    next_state  = BUSY;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= EMPTY;
            q_reg     <= '0;
            skid_reg  <= '0;
            ready_reg <= 1'b0;
        end else begin
            state <= next_state;
            // Ready is precomputed from the next state so it stays a pure flop.
            ready_reg <= (next_state != FULL);
            if (load_q) begin
                q_reg <= d;
            end else if (q_from_skid) begin
                q_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= d;
            end
        end
    end

endmodule

// File: tb/tb_mux_skid_reg.sv
module tb_mux_skid_reg;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] d;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] q;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] count;

    int errors = 0;
    int checks = 0;

    mux_skid_reg #(.DATAWIDTH(8)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .d        (d),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .q        (q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] eq, input logic ev,
                               input logic [1:0] ec, input logic er);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".count"}, 32'(count), 32'(ec));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    endtask

    initial begin
        Rst = 1'b1; in_valid = 1'b1; d = 8'hAA; out_ready = 1'b0;

        // Reset held two cycles with a valid word offered.
        step();
        step();
        check_state("reset", 8'h00, 1'b0, 2'd0, 1'b0);
        Rst = 1'b0;
        #1;
        check("post_reset_ready_low", 32'(in_ready), 32'd0);
        step();
        check_state("post_reset", 8'h00, 1'b0, 2'd0, 1'b1);
        in_valid = 1'b0;

        // Streaming at full throughput.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            d = 8'(i);
            in_valid = 1'b1;
            step();
            check($sformatf("stream%0d.q", i), 32'(q), 32'(i));
            check($sformatf("stream%0d.count", i), 32'(count), 32'd1);
            check($sformatf("stream%0d.valid", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain.count", 32'(count), 32'd0);

        // Stall fill.
        out_ready = 1'b0;
        in_valid = 1'b1; d = 8'h11;
        step();
        check_state("fill1", 8'h11, 1'b1, 2'd1, 1'b1);
        d = 8'h22;
        step();
        check_state("fill2", 8'h11, 1'b1, 2'd2, 1'b0);
        d = 8'h33;
        step();
        check_state("full_hold", 8'h11, 1'b1, 2'd2, 1'b0);
        step();
        check("full_hold2.q", 32'(q), 32'h11);

        // Drain: 11 leaves, then 22 shown, then 33 accepted and shown.
        out_ready = 1'b1;
        step();
        check_state("drain1", 8'h22, 1'b1, 2'd1, 1'b1);
        step();
        check_state("drain2", 8'h33, 1'b1, 2'd1, 1'b1);
        in_valid = 1'b0;
        step();
        check("drain3.count", 32'(count), 32'd0);
        check("drain3.valid", 32'(out_valid), 32'd0);

        // Simultaneous in/out fire in BUSY.
        out_ready = 1'b0;
        in_valid = 1'b1; d = 8'h44;
        step();
        check_state("simul_load", 8'h44, 1'b1, 2'd1, 1'b1);
        out_ready = 1'b1; d = 8'h55;
        step();
        check_state("simul_fire", 8'h55, 1'b1, 2'd1, 1'b1);
        in_valid = 1'b0;
        step();
        check("simul_drain.count", 32'(count), 32'd0);

        // Reset while FULL discards both words.
        out_ready = 1'b0;
        in_valid = 1'b1; d = 8'h66;
        step();
        d = 8'h77;
        step();
        check_state("prefill", 8'h66, 1'b1, 2'd2, 1'b0);
        Rst = 1'b1; in_valid = 1'b0; d = 8'hXX;
        step();
        check_state("mid_reset", 8'h00, 1'b0, 2'd0, 1'b0);
        Rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("after_reset%0d.valid", i), 32'(out_valid), 32'd0);
            check($sformatf("after_reset%0d.q", i), 32'(q), 32'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
